// File: rtl/qa_drv_prim_filter_gate_pkg.sv
// Shared types and the address-to-bucket hash for the filter-gated request driver.
package qa_drv_prim_filter_gate_pkg;

   localparam int unsigned MAX_BUCKET_W = 16;
   localparam int unsigned MAX_TAG_W    = 16;
   localparam int unsigned HASH_ADDR_W  = 64;

   typedef logic [MAX_BUCKET_W-1:0] t_bucket_idx;
   typedef logic [MAX_TAG_W-1:0]    t_tag;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } t_hold_state;

   // Folds the two lowest bw-bit address fields together; callers size-cast to their bucket width.
   function automatic t_bucket_idx bucket_hash(input logic [HASH_ADDR_W-1:0] addr,
                                               input int unsigned bw);
      t_bucket_idx mask;
      mask = (t_bucket_idx'(1) << bw) - t_bucket_idx'(1);
      return t_bucket_idx'(addr ^ (addr >> bw)) & mask;
   endfunction

endpackage

// File: rtl/qa_drv_prim_tag_pool.sv
// Completion-tag pool: busy bitmap with a lowest-free-tag priority encoder.
module qa_drv_prim_tag_pool
   import qa_drv_prim_filter_gate_pkg::*;
#(
   parameter int unsigned N_TAGS = 32,
   parameter int unsigned TW     = $clog2(N_TAGS)
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              alloc_i,
   output logic [TW-1:0]     alloc_tag_o,
   output logic              any_free_o,
   input  logic              free_i,
   input  logic [TW-1:0]     free_tag_i,
   output logic [N_TAGS-1:0] busy_o
);

   logic [N_TAGS-1:0] busy_q, busy_d;
   t_tag              lowestFree;

   // Scanning downward leaves the lowest clear bit as the final winner.
   always_comb begin
      lowestFree = '0;
      for (int i = N_TAGS - 1; i >= 0; i--) begin
         if (!busy_q[i]) lowestFree = t_tag'(i);
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (free_i)  busy_d[free_tag_i]  = 1'b0;
      if (alloc_i) busy_d[alloc_tag_o] = 1'b1;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   assign alloc_tag_o = TW'(lowestFree);
   assign any_free_o  = ~&busy_q;
   assign busy_o      = busy_q;

endmodule

// File: rtl/qa_drv_prim_filter_gate.sv
// Issue-side driver for a counting filter: holds one request, gates issue on bucket
// occupancy, allocates completion tags and drives the filter insert/remove ports.
module qa_drv_prim_filter_gate
   import qa_drv_prim_filter_gate_pkg::*;
#(
   parameter int unsigned N_BUCKETS  = 16,
   parameter int unsigned N_TAGS     = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           resetb,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [ADDR_WIDTH-1:0]          req_addr,
   output logic                           issue_valid,
   input  logic                           issue_ready,
   output logic [ADDR_WIDTH-1:0]          issue_addr,
   output logic [$clog2(N_TAGS)-1:0]      issue_tag,
   input  logic                           rsp_valid,
   input  logic [$clog2(N_TAGS)-1:0]      rsp_tag,
   output logic [$clog2(N_BUCKETS)-1:0]   filt_test_req,
   input  logic                           filt_test_notFull,
   output logic [$clog2(N_BUCKETS)-1:0]   filt_insert,
   output logic                           filt_insert_en,
   output logic [$clog2(N_BUCKETS)-1:0]   filt_remove,
   output logic                           filt_remove_en,
   output logic [$clog2(N_TAGS+1)-1:0]    outstanding,
   output logic                           idle,
   output logic                           err_bad_tag
);

   localparam int unsigned BW = $clog2(N_BUCKETS);
   localparam int unsigned TW = $clog2(N_TAGS);
   localparam int unsigned CW = $clog2(N_TAGS + 1);

   logic                  running_q;
   t_hold_state           holdState_q, holdState_d;
   logic [ADDR_WIDTH-1:0] holdAddr_q, holdAddr_d;
   logic [BW-1:0]         holdBucket_q, holdBucket_d;
   logic [CW-1:0]         outstanding_q, outstanding_d;
   logic                  errBadTag_q;
   logic [BW-1:0]         tagTable_q [N_TAGS];

   logic [BW-1:0]         reqBucket;
   logic [TW-1:0]         allocTag;
   logic [N_TAGS-1:0]     tagBusy;
   logic                  anyFree;
   logic                  reqFire, issueFire, rspHit, rspBad;

   assign reqBucket = BW'(bucket_hash(HASH_ADDR_W'(req_addr), BW));

   // running_q keeps req_ready low while reset is held and rises on the first edge after release.
   assign issue_valid = (holdState_q == HOLD_FULL) && filt_test_notFull && anyFree;
   assign issueFire   = issue_valid && issue_ready;
   assign req_ready   = running_q && ((holdState_q == HOLD_EMPTY) || issueFire);
   assign reqFire     = req_valid && req_ready;
   assign rspHit      = rsp_valid && tagBusy[rsp_tag];
   assign rspBad      = rsp_valid && !tagBusy[rsp_tag];

   assign issue_addr     = holdAddr_q;
   assign issue_tag      = allocTag;
   assign filt_test_req  = holdBucket_q;
   assign filt_insert    = holdBucket_q;
   assign filt_insert_en = issueFire;
   assign filt_remove    = tagTable_q[rsp_tag];
   assign filt_remove_en = rspHit;
   assign outstanding    = outstanding_q;
   assign idle           = (holdState_q == HOLD_EMPTY) && (outstanding_q == '0);
   assign err_bad_tag    = errBadTag_q;

   qa_drv_prim_tag_pool #(
      .N_TAGS (N_TAGS),
      .TW     (TW)
   ) u_tag_pool (
      .clk         (clk),
      .resetb      (resetb),
      .alloc_i     (issueFire),
      .alloc_tag_o (allocTag),
      .any_free_o  (anyFree),
      .free_i      (rspHit),
      .free_tag_i  (rsp_tag),
      .busy_o      (tagBusy)
   );

   // A new request can land in the same cycle the held one issues, keeping the register FULL.
   always_comb begin
      holdState_d  = holdState_q;
      holdAddr_d   = holdAddr_q;
      holdBucket_d = holdBucket_q;
      if (reqFire) begin
         holdState_d  = HOLD_FULL;
         holdAddr_d   = req_addr;
         holdBucket_d = reqBucket;
      end else if (issueFire) begin
         holdState_d  = HOLD_EMPTY;
      end
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (issueFire && !rspHit)      outstanding_d = outstanding_q + CW'(1);
      else if (!issueFire && rspHit) outstanding_d = outstanding_q - CW'(1);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         running_q     <= 1'b0;
         holdState_q   <= HOLD_EMPTY;
         holdAddr_q    <= '0;
         holdBucket_q  <= '0;
         outstanding_q <= '0;
         errBadTag_q   <= 1'b0;
      end else begin
         running_q     <= 1'b1;
         holdState_q   <= holdState_d;
         holdAddr_q    <= holdAddr_d;
         holdBucket_q  <= holdBucket_d;
         outstanding_q <= outstanding_d;
         if (rspBad) errBadTag_q <= 1'b1;
      end
   end

   // Entries are only read for busy tags, so the table needs no reset.
   always_ff @(posedge clk) begin
      if (issueFire) tagTable_q[allocTag] <= holdBucket_q;
   end

endmodule

// File: tb/tb_qa_drv_prim_filter_gate.sv
// Directed bench: a 4-tag instance for tag/ordering behaviour and a 16-tag instance
// for filter back-pressure, each paired with a behavioural counting-filter model.
module tb_qa_drv_prim_filter_gate;

   logic clk = 1'b0;
   logic resetb = 1'b0;
   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   logic        reqValidA = 0, issueReadyA = 0, rspValidA = 0;
   logic [31:0] reqAddrA = '0;
   logic [1:0]  rspTagA = '0;
   logic        reqReadyA, issueValidA, filtInsertEnA, filtRemoveEnA, idleA, errBadTagA, notFullA;
   logic [31:0] issueAddrA;
   logic [1:0]  issueTagA;
   logic [3:0]  filtTestReqA, filtInsertA, filtRemoveA;
   logic [2:0]  outstandingA;

   logic        reqValidB = 0, issueReadyB = 0, rspValidB = 0;
   logic [31:0] reqAddrB = '0;
   logic [3:0]  rspTagB = '0;
   logic        reqReadyB, issueValidB, filtInsertEnB, filtRemoveEnB, idleB, errBadTagB, notFullB;
   logic [31:0] issueAddrB;
   logic [3:0]  issueTagB;
   logic [3:0]  filtTestReqB, filtInsertB, filtRemoveB;
   logic [4:0]  outstandingB;

   qa_drv_prim_filter_gate #(.N_BUCKETS(16), .N_TAGS(4), .ADDR_WIDTH(32)) dutA (
      .clk(clk), .resetb(resetb),
      .req_valid(reqValidA), .req_ready(reqReadyA), .req_addr(reqAddrA),
      .issue_valid(issueValidA), .issue_ready(issueReadyA), .issue_addr(issueAddrA), .issue_tag(issueTagA),
      .rsp_valid(rspValidA), .rsp_tag(rspTagA),
      .filt_test_req(filtTestReqA), .filt_test_notFull(notFullA),
      .filt_insert(filtInsertA), .filt_insert_en(filtInsertEnA),
      .filt_remove(filtRemoveA), .filt_remove_en(filtRemoveEnA),
      .outstanding(outstandingA), .idle(idleA), .err_bad_tag(errBadTagA)
   );

   qa_drv_prim_filter_gate #(.N_BUCKETS(16), .N_TAGS(16), .ADDR_WIDTH(32)) dutB (
      .clk(clk), .resetb(resetb),
      .req_valid(reqValidB), .req_ready(reqReadyB), .req_addr(reqAddrB),
      .issue_valid(issueValidB), .issue_ready(issueReadyB), .issue_addr(issueAddrB), .issue_tag(issueTagB),
      .rsp_valid(rspValidB), .rsp_tag(rspTagB),
      .filt_test_req(filtTestReqB), .filt_test_notFull(notFullB),
      .filt_insert(filtInsertB), .filt_insert_en(filtInsertEnB),
      .filt_remove(filtRemoveB), .filt_remove_en(filtRemoveEnB),
      .outstanding(outstandingB), .idle(idleB), .err_bad_tag(errBadTagB)
   );

   // Counting filters with 4-bit buckets; a bucket reports full once its counter reaches 8.
   logic [3:0] cntA [16];
   logic [3:0] cntB [16];

   always @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < 16; i++) cntA[i] <= '0;
      end else begin
         if (filtInsertEnA && !(filtRemoveEnA && filtRemoveA == filtInsertA)) cntA[filtInsertA] <= cntA[filtInsertA] + 4'd1;
         if (filtRemoveEnA && !(filtInsertEnA && filtRemoveA == filtInsertA)) cntA[filtRemoveA] <= cntA[filtRemoveA] - 4'd1;
      end
   end

   always @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int j = 0; j < 16; j++) cntB[j] <= '0;
      end else begin
         if (filtInsertEnB && !(filtRemoveEnB && filtRemoveB == filtInsertB)) cntB[filtInsertB] <= cntB[filtInsertB] + 4'd1;
         if (filtRemoveEnB && !(filtInsertEnB && filtRemoveB == filtInsertB)) cntB[filtRemoveB] <= cntB[filtRemoveB] - 4'd1;
      end
   end

   assign notFullA = cntA[filtTestReqA] < 4'd8;
   assign notFullB = cntB[filtTestReqB] < 4'd8;

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      resetb = 1'b0;
      #2;
      checkCount++; if (reqReadyA !== 1'b0) $display("[TB] FAIL reset_req_ready: got %0h want 0", reqReadyA); else passCount++;
      checkCount++; if (issueValidA !== 1'b0) $display("[TB] FAIL reset_issue_valid: got %0h want 0", issueValidA); else passCount++;
      checkCount++; if ({filtInsertEnA, filtRemoveEnA} !== 2'b00) $display("[TB] FAIL reset_filt_en: got %0h want 0", {filtInsertEnA, filtRemoveEnA}); else passCount++;
      checkCount++; if (outstandingA !== 3'd0) $display("[TB] FAIL reset_outstanding: got %0d want 0", outstandingA); else passCount++;
      checkCount++; if (idleA !== 1'b1) $display("[TB] FAIL reset_idle: got %0h want 1", idleA); else passCount++;
      checkCount++; if (errBadTagA !== 1'b0) $display("[TB] FAIL reset_err: got %0h want 0", errBadTagA); else passCount++;
      nextCycle();
      nextCycle();
      resetb = 1'b1;
      nextCycle();
      checkCount++; if (reqReadyA !== 1'b1) $display("[TB] FAIL post_reset_ready_a: got %0h want 1", reqReadyA); else passCount++;
      checkCount++; if (reqReadyB !== 1'b1) $display("[TB] FAIL post_reset_ready_b: got %0h want 1", reqReadyB); else passCount++;
   endtask

   task automatic test_first_issue;
      issueReadyA = 1'b1;
      reqValidA = 1'b1; reqAddrA = 32'h12;
      nextCycle();
      reqValidA = 1'b0;
      #1;
      checkCount++; if (issueValidA !== 1'b1) $display("[TB] FAIL first_issue_valid: got %0h want 1", issueValidA); else passCount++;
      checkCount++; if (issueTagA !== 2'd0) $display("[TB] FAIL first_issue_tag: got %0d want 0", issueTagA); else passCount++;
      checkCount++; if ({filtInsertEnA, filtInsertA} !== {1'b1, 4'd3}) $display("[TB] FAIL first_insert: got %0h want 13", {filtInsertEnA, filtInsertA}); else passCount++;
      checkCount++; if (issueAddrA !== 32'h12) $display("[TB] FAIL first_issue_addr: got %0h want 12", issueAddrA); else passCount++;
      nextCycle();
      checkCount++; if (outstandingA !== 3'd1) $display("[TB] FAIL first_outstanding: got %0d want 1", outstandingA); else passCount++;
      checkCount++; if (issueValidA !== 1'b0) $display("[TB] FAIL first_drained: got %0h want 0", issueValidA); else passCount++;
      rspValidA = 1'b1; rspTagA = 2'd0;
      #1;
      checkCount++; if ({filtRemoveEnA, filtRemoveA} !== {1'b1, 4'd3}) $display("[TB] FAIL first_remove: got %0h want 13", {filtRemoveEnA, filtRemoveA}); else passCount++;
      nextCycle();
      rspValidA = 1'b0;
      #1;
      checkCount++; if (idleA !== 1'b1) $display("[TB] FAIL first_idle: got %0h want 1", idleA); else passCount++;
   endtask

   task automatic test_tag_exhaust;
      logic [31:0] addrs [5];
      addrs[0] = 32'h10; addrs[1] = 32'h21; addrs[2] = 32'h35; addrs[3] = 32'h43; addrs[4] = 32'h54;
      issueReadyA = 1'b1;
      for (int i = 0; i < 5; i++) begin
         reqValidA = 1'b1; reqAddrA = addrs[i];
         #1;
         if (i > 0) begin
            checkCount++; if (issueTagA !== 2'(i - 1) || issueValidA !== 1'b1) $display("[TB] FAIL exhaust_tag%0d: got %0d/%0h want %0d/1", i - 1, issueTagA, issueValidA, i - 1); else passCount++;
         end
         nextCycle();
      end
      reqValidA = 1'b0;
      #1;
      checkCount++; if (issueValidA !== 1'b0) $display("[TB] FAIL exhaust_stall: got %0h want 0", issueValidA); else passCount++;
      checkCount++; if (outstandingA !== 3'd4) $display("[TB] FAIL exhaust_outstanding: got %0d want 4", outstandingA); else passCount++;
      checkCount++; if (reqReadyA !== 1'b0) $display("[TB] FAIL exhaust_req_ready: got %0h want 0", reqReadyA); else passCount++;
      rspValidA = 1'b1; rspTagA = 2'd2;
      #1;
      checkCount++; if ({filtRemoveEnA, filtRemoveA} !== {1'b1, 4'd6}) $display("[TB] FAIL exhaust_remove: got %0h want 16", {filtRemoveEnA, filtRemoveA}); else passCount++;
      checkCount++; if (issueValidA !== 1'b0) $display("[TB] FAIL exhaust_same_cycle_realloc: got %0h want 0", issueValidA); else passCount++;
      nextCycle();
      rspValidA = 1'b0;
      #1;
      checkCount++; if (issueValidA !== 1'b1 || issueTagA !== 2'd2) $display("[TB] FAIL exhaust_reissue: got %0h/%0d want 1/2", issueValidA, issueTagA); else passCount++;
      checkCount++; if (issueAddrA !== 32'h54) $display("[TB] FAIL exhaust_reissue_addr: got %0h want 54", issueAddrA); else passCount++;
      nextCycle();
      checkCount++; if (outstandingA !== 3'd4) $display("[TB] FAIL exhaust_refilled: got %0d want 4", outstandingA); else passCount++;
      for (int t = 0; t < 4; t++) begin
         rspValidA = 1'b1; rspTagA = 2'(t);
         nextCycle();
      end
      rspValidA = 1'b0;
      #1;
      checkCount++; if (outstandingA !== 3'd0 || idleA !== 1'b1) $display("[TB] FAIL exhaust_drain: got %0d/%0h want 0/1", outstandingA, idleA); else passCount++;
   endtask

   task automatic test_back_to_back;
      issueReadyA = 1'b1;
      reqValidA = 1'b1; reqAddrA = 32'h12;
      nextCycle();
      reqAddrA = 32'h21;
      nextCycle();
      reqValidA = 1'b0;
      rspValidA = 1'b1; rspTagA = 2'd0;
      #1;
      checkCount++; if (issueValidA !== 1'b1 || issueTagA !== 2'd1) $display("[TB] FAIL b2b_issue: got %0h/%0d want 1/1", issueValidA, issueTagA); else passCount++;
      checkCount++; if ({filtInsertEnA, filtInsertA, filtRemoveEnA, filtRemoveA} !== 10'b1_0011_1_0011) $display("[TB] FAIL b2b_pulses: got %0h want 273", {filtInsertEnA, filtInsertA, filtRemoveEnA, filtRemoveA}); else passCount++;
      nextCycle();
      rspValidA = 1'b0;
      #1;
      checkCount++; if (outstandingA !== 3'd1) $display("[TB] FAIL b2b_outstanding: got %0d want 1", outstandingA); else passCount++;
      checkCount++; if ({filtInsertEnA, filtRemoveEnA} !== 2'b00) $display("[TB] FAIL b2b_single_pulse: got %0h want 0", {filtInsertEnA, filtRemoveEnA}); else passCount++;
      rspValidA = 1'b1; rspTagA = 2'd1;
      nextCycle();
      rspValidA = 1'b0;
      #1;
      checkCount++; if (idleA !== 1'b1) $display("[TB] FAIL b2b_idle: got %0h want 1", idleA); else passCount++;
   endtask

   task automatic test_bad_tag;
      rspValidA = 1'b1; rspTagA = 2'd1;
      #1;
      checkCount++; if (filtRemoveEnA !== 1'b0) $display("[TB] FAIL bad_tag_remove_en: got %0h want 0", filtRemoveEnA); else passCount++;
      nextCycle();
      rspValidA = 1'b0;
      #1;
      checkCount++; if (errBadTagA !== 1'b1) $display("[TB] FAIL bad_tag_err: got %0h want 1", errBadTagA); else passCount++;
      checkCount++; if (outstandingA !== 3'd0) $display("[TB] FAIL bad_tag_outstanding: got %0d want 0", outstandingA); else passCount++;
      nextCycle();
      nextCycle();
      checkCount++; if (errBadTagA !== 1'b1) $display("[TB] FAIL bad_tag_sticky: got %0h want 1", errBadTagA); else passCount++;
   endtask

   task automatic test_filter_stall;
      issueReadyB = 1'b1;
      for (int i = 0; i < 9; i++) begin
         reqValidB = 1'b1; reqAddrB = (i % 2 == 0) ? 32'h12 : 32'h21;
         #1;
         if (i > 0) begin
            checkCount++; if (issueTagB !== 4'(i - 1) || issueValidB !== 1'b1) $display("[TB] FAIL stall_tag%0d: got %0d/%0h want %0d/1", i - 1, issueTagB, issueValidB, i - 1); else passCount++;
         end
         nextCycle();
      end
      reqValidB = 1'b0;
      #1;
      checkCount++; if (issueValidB !== 1'b0) $display("[TB] FAIL stall_ninth: got %0h want 0", issueValidB); else passCount++;
      checkCount++; if (outstandingB !== 5'd8) $display("[TB] FAIL stall_outstanding: got %0d want 8", outstandingB); else passCount++;
      checkCount++; if (filtTestReqB !== 4'd3) $display("[TB] FAIL stall_test_req: got %0d want 3", filtTestReqB); else passCount++;
      nextCycle();
      rspValidB = 1'b1; rspTagB = 4'd4;
      #1;
      checkCount++; if ({filtRemoveEnB, filtRemoveB} !== {1'b1, 4'd3} || issueValidB !== 1'b0) $display("[TB] FAIL stall_completion: got %0h/%0h want 13/0", {filtRemoveEnB, filtRemoveB}, issueValidB); else passCount++;
      nextCycle();
      rspValidB = 1'b0;
      #1;
      checkCount++; if (issueValidB !== 1'b1 || issueTagB !== 4'd4) $display("[TB] FAIL stall_release: got %0h/%0d want 1/4", issueValidB, issueTagB); else passCount++;
      nextCycle();
      checkCount++; if (outstandingB !== 5'd8) $display("[TB] FAIL stall_reissued: got %0d want 8", outstandingB); else passCount++;
   endtask

   task automatic test_mid_reset;
      logic [31:0] addrs [4];
      addrs[0] = 32'h10; addrs[1] = 32'h21; addrs[2] = 32'h35; addrs[3] = 32'h43;
      issueReadyA = 1'b1;
      for (int i = 0; i < 4; i++) begin
         reqValidA = 1'b1; reqAddrA = addrs[i];
         nextCycle();
      end
      reqValidA = 1'b0; issueReadyA = 1'b0;
      #1;
      checkCount++; if (outstandingA !== 3'd3 || issueValidA !== 1'b1 || issueTagA !== 2'd3) $display("[TB] FAIL mid_pre: got %0d/%0h/%0d want 3/1/3", outstandingA, issueValidA, issueTagA); else passCount++;
      #1;
      resetb = 1'b0;
      #1;
      checkCount++; if (issueValidA !== 1'b0 || reqReadyA !== 1'b0) $display("[TB] FAIL mid_reset_handshake: got %0h/%0h want 0/0", issueValidA, reqReadyA); else passCount++;
      checkCount++; if (outstandingA !== 3'd0 || idleA !== 1'b1) $display("[TB] FAIL mid_reset_count: got %0d/%0h want 0/1", outstandingA, idleA); else passCount++;
      checkCount++; if (errBadTagA !== 1'b0) $display("[TB] FAIL mid_reset_err: got %0h want 0", errBadTagA); else passCount++;
      checkCount++; if (outstandingB !== 5'd0) $display("[TB] FAIL mid_reset_b: got %0d want 0", outstandingB); else passCount++;
      nextCycle();
      resetb = 1'b1;
      nextCycle();
      checkCount++; if (idleA !== 1'b1 || reqReadyA !== 1'b1) $display("[TB] FAIL mid_release: got %0h/%0h want 1/1", idleA, reqReadyA); else passCount++;
      issueReadyA = 1'b1;
      reqValidA = 1'b1; reqAddrA = 32'h12;
      nextCycle();
      reqValidA = 1'b0;
      #1;
      checkCount++; if (issueValidA !== 1'b1 || issueTagA !== 2'd0) $display("[TB] FAIL mid_first_tag: got %0h/%0d want 1/0", issueValidA, issueTagA); else passCount++;
      nextCycle();
      checkCount++; if (outstandingA !== 3'd1) $display("[TB] FAIL mid_outstanding: got %0d want 1", outstandingA); else passCount++;
   endtask

   initial begin
      $display("[TB] starting");
      test_reset();
      test_first_issue();
      test_tag_exhaust();
      test_back_to_back();
      test_bad_tag();
      test_filter_stall();
      test_mid_reset();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/qa_drv_prim_filter_gate.md
# qa_drv_prim_filter_gate

Issue-side driver for the counting filter: accepts tagged-less memory requests, hashes each address to a filter bucket, gates issue on the bucket's `test_notFull`, allocates a completion tag, and drives the filter's `insert` port on issue and `remove` port on completion. It sits between a request source and the memory channel, so other clients can probe the same filter's `test_isZero` to detect in-flight conflicts.

## Interface
- `N_BUCKETS`, 16: filter bucket count; power of two, ≥ 2.
- `N_TAGS`, 32: maximum outstanding requests; power of two.
- `ADDR_WIDTH`, 32: request address width; must be ≥ 2·log2(N_BUCKETS).

Ports:
- `clk`  in  1  sole clock.
- `resetb`  in  1  reset, asynchronous, active-low.
- `req_valid` / `req_ready`  in / out  1 / 1  upstream valid/ready.
- `req_addr`  in  ADDR_WIDTH  request address.
- `issue_valid` / `issue_ready`  out / in  1 / 1  downstream valid/ready.
- `issue_addr`  out  ADDR_WIDTH  issued address.
- `issue_tag`  out  log2(N_TAGS)  allocated tag.
- `rsp_valid`  in  1  completion strobe; no backpressure.
- `rsp_tag`  in  log2(N_TAGS)  completed tag.
- `filt_test_req`  out  log2(N_BUCKETS)  bucket to test.
- `filt_test_notFull`  in  1  filter result for `filt_test_req`, same cycle.
- `filt_insert` / `filt_insert_en`  out  log2(N_BUCKETS) / 1  filter insert port.
- `filt_remove` / `filt_remove_en`  out  log2(N_BUCKETS) / 1  filter remove port.
- `outstanding`  out  log2(N_TAGS+1)  live tag count.
- `idle`  out  1  holding register empty and `outstanding`==0.
- `err_bad_tag`  out  1  sticky: completion for a free tag.

## Operation
- Bucket hash: bucket = addr[L-1:0] XOR addr[2L-1:L], where L = log2(N_BUCKETS).
- Holding register, states EMPTY/FULL. EMPTY→FULL on req fire. FULL→EMPTY on issue fire with no new req. FULL→FULL on simultaneous issue and req fire.
- `req_ready` = EMPTY or issue fire this cycle. Combinational path from `issue_ready` is permitted.
- `filt_test_req` = registered bucket of the held address, driven continuously.
- `issue_valid` = FULL and `filt_test_notFull` and any tag free.
- `issue_tag` = lowest-numbered free tag.
- Issue fire:
  - `filt_insert_en`=1 with the held bucket.
  - Tag marked busy at the next edge.
  - Bucket written to the tag table at the next edge.
- Completion, `rsp_valid` with `rsp_tag` busy:
  - `filt_remove_en`=1 and `filt_remove` = table[rsp_tag], combinationally, same cycle.
  - Tag freed at the next edge.
  - A freed tag is allocatable from the following cycle, never in the same cycle.
- Completion with `rsp_tag` free: no remove, no state change; `err_bad_tag` set and held until reset.
- `outstanding`: +1 on issue fire, −1 on valid completion, unchanged when both occur. Never wraps; N_TAGS bounds it.

## Timing
- While `resetb`=0, outputs are forced to:
  - `req_ready`=0, `issue_valid`=0, both filter enables 0.
  - `outstanding`=0, `idle`=1, `err_bad_tag`=0.
- All tags free; holding register EMPTY.
- `req_ready`=1 from the first cycle after reset deassertion.
- Latency: req fire at cycle N → `issue_valid` earliest at N+1.
- Filter counts update at the edge after insert/remove, so a back-to-back issue to the same bucket tests the post-insert count.
- `issue_addr`/`issue_tag` stable while `issue_valid`=1 and `issue_ready`=0, unless a completion frees a lower tag. In that case `issue_tag` may change; downstream samples only on fire.
- Reset mid-operation discards held and outstanding state. The filter shares `resetb`, so the counts clear coherently.

## Structure
- Package `qa_drv_prim_filter_gate_pkg` holds:
  - `t_bucket_idx` and `t_tag` typedefs.
  - `bucket_hash()` function.
- Sub-module `qa_drv_prim_tag_pool`:
  - busy bitmap, lowest-free priority encoder, `any_free`.
  - alloc/free ports; alloc and free of different tags in the same cycle.
- Tag table: flop array of N_TAGS × t_bucket_idx in the top level.

## Test plan
Bench parameters: N_BUCKETS=16, N_TAGS=4, real filter with BITS_PER_BUCKET=4.
- Reset, then req 0x12 at cycle 0 with `issue_ready`=1 → cycle 1: `issue_valid`, tag 0, `filt_insert`=3 with enable; `outstanding`=1 at cycle 2.
- Four reqs, no completions → tags 0,1,2,3 issued; 5th held with `issue_valid`=0. `rsp_tag`=2 → cycle after: 5th issues with tag 2; `filt_remove` equals tag 2's bucket on the completion cycle.
- N_TAGS=16, eight reqs to 0x12/0x21 (both bucket 3) → ninth stalls (`notFull`=0); one completion → ninth issues exactly one cycle after the count drops to 7.
- Same-cycle issue fire and completion of a different tag → `outstanding` unchanged; one insert and one remove pulse.
- `rsp_tag`=1 with tag 1 free → `err_bad_tag`=1 sticky, `filt_remove_en`=0, `outstanding` unchanged.
- Assert `resetb`=0 with 3 outstanding and the register FULL → outputs immediately at reset values; after release `idle`=1 and tag 0 is allocated first.
